// File: rtl/brightness_sequencer.sv
// brightness_sequencer: multi-channel staggered brightness stepper.
// Each channel walks a triangle, sawtooth or held pattern between 0 and a
// runtime peak, stepping once every IDLE_TIME enabled clocks. Channel k
// starts at k*STAGGER so adjacent channels stay phase-offset.
module brightness_sequencer #(
  parameter int WIDTH     = 8,
  parameter int CHANNELS  = 3,
  parameter int IDLE_TIME = 16,
  parameter int STEP      = 1,
  parameter int STAGGER   = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      enable,
  input  logic [1:0]                mode,
  input  logic [WIDTH-1:0]          peak,
  output logic [CHANNELS*WIDTH-1:0] brightness,
  output logic                      cycle_start
);

  typedef enum logic [1:0] {
    M_TRI      = 2'd0,
    M_SAW_UP   = 2'd1,
    M_SAW_DOWN = 2'd2,
    M_HOLD     = 2'd3
  } mode_e;

  localparam int PW = (IDLE_TIME > 1) ? $clog2(IDLE_TIME) : 1;
  localparam int SW = WIDTH + 1;
  localparam logic [SW-1:0]    STEP_W = SW'(STEP);
  localparam logic [WIDTH-1:0] STEP_V = WIDTH'(STEP);

  logic [PW-1:0]                    presc_q;
  logic                             tick;
  logic [CHANNELS-1:0][WIDTH-1:0]   val_all;
  logic [CHANNELS-1:0][WIDTH-1:0]   nxt_all;

  assign tick       = enable && (presc_q == PW'(IDLE_TIME - 1));
  assign brightness = val_all;

  // Prescaler: free-runs while enabled, holds its count during pause.
  always_ff @(posedge clk) begin
    if (!reset)      presc_q <= '0;
    else if (tick)   presc_q <= '0;
    else if (enable) presc_q <= presc_q + PW'(1);
  end

  for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
    localparam logic [WIDTH-1:0] INIT_V = WIDTH'(k * STAGGER);

    logic [WIDTH-1:0] v_q, nv, up_v, dn_v, rst_v;
    logic [SW-1:0]    up_sum;
    logic             dir_q, nd; // dir 1 = counting down

    assign rst_v      = (INIT_V > peak) ? peak : INIT_V;
    assign val_all[k] = v_q;
    assign nxt_all[k] = nv;

    // Next value/direction; arithmetic is one bit wider so nothing wraps.
    always_comb begin
      up_sum = {1'b0, v_q} + STEP_W;
      up_v   = (up_sum >= {1'b0, peak}) ? peak : up_sum[WIDTH-1:0];
      dn_v   = ({1'b0, v_q} <= STEP_W) ? '0 : (v_q - STEP_V);
      nv     = v_q;
      nd     = dir_q;
      case (mode_e'(mode))
        M_TRI: begin
          if (v_q > peak) begin
            nv = peak;
            nd = 1'b1;
          end else if (!dir_q) begin
            nv = up_v;
            if (up_v == peak) nd = 1'b1;
          end else begin
            nv = dn_v;
            if (dn_v == '0) nd = 1'b0;
          end
        end
        M_SAW_UP: begin
          if (v_q > peak)       nv = peak;
          else if (v_q == peak) nv = '0;
          else                  nv = up_v;
        end
        M_SAW_DOWN: begin
          if (v_q > peak)      nv = peak;
          else if (v_q == '0)  nv = peak;
          else                 nv = dn_v;
        end
        default: begin
          nv = v_q;
          nd = dir_q;
        end
      endcase
    end

    // Channel state: staggered reset value, advance only on the tick edge.
    always_ff @(posedge clk) begin
      if (!reset) begin
        v_q   <= rst_v;
        dir_q <= (rst_v == peak) && (peak != '0);
      end else if (tick) begin
        v_q   <= nv;
        dir_q <= nd;
      end
    end
  end

  // Period marker: channel 0 newly lands on its wrap point (0, or peak for
  // SAW_DOWN). With peak==0 every tick lands there, so every tick pulses.
  logic [WIDTH-1:0] cs_target;
  logic             cs_hit;
  assign cs_target = (mode == M_SAW_DOWN) ? peak : '0;
  assign cs_hit    = (nxt_all[0] == cs_target) &&
                     ((val_all[0] != cs_target) || (peak == '0));

  // Registered pulse, one cycle wide, aligned with the new output value.
  always_ff @(posedge clk) begin
    if (!reset) cycle_start <= 1'b0;
    else        cycle_start <= tick && (mode != M_HOLD) && cs_hit;
  end

endmodule

// File: tb/tb_brightness_sequencer.sv
// tb_brightness_sequencer: directed checks of two sequencer instances
// (STEP=1 and STEP=4) with WIDTH=4, CHANNELS=2, IDLE_TIME=4, STAGGER=5.
module tb_brightness_sequencer;

  logic       clk = 1'b0;
  logic       reset, enable;
  logic [1:0] mode;
  logic [3:0] pk1, pk4;
  logic [7:0] br1, br4;
  logic       cs1, cs4;
  int         total = 0;
  int         bad   = 0;

  always #5 clk = ~clk;

  brightness_sequencer #(.WIDTH(4), .CHANNELS(2), .IDLE_TIME(4), .STEP(1), .STAGGER(5)) u_d1 (
    .clk(clk), .reset(reset), .enable(enable), .mode(mode), .peak(pk1),
    .brightness(br1), .cycle_start(cs1));

  brightness_sequencer #(.WIDTH(4), .CHANNELS(2), .IDLE_TIME(4), .STEP(4), .STAGGER(5)) u_d4 (
    .clk(clk), .reset(reset), .enable(enable), .mode(mode), .peak(pk4),
    .brightness(br4), .cycle_start(cs4));

  typedef struct {
    logic       rst;
    logic       en;
    logic [1:0] md;
    logic [3:0] pk;
    int         adv;
    logic [3:0] e0;
    logic [3:0] e1;
    logic       ecs;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input int r, input int e, input int m, input int p,
                              input int a, input int x0, input int x1, input int xc);
    vec_t v;
    v.rst = 1'(r);  v.en = 1'(e);  v.md = 2'(m);  v.pk = 4'(p);
    v.adv = a;      v.e0 = 4'(x0); v.e1 = 4'(x1); v.ecs = 1'(xc);
    tbl.push_back(v);
  endfunction

  task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic adv(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Triangle 0..15..0 over a 30-step period.
  function automatic int tri30(input int x);
    return (x <= 15) ? x : 30 - x;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int seq4[6] = '{0, 4, 8, 10, 6, 2};
    int s;

    // pause
    add(0,1,0,15, 2,  0, 5,0);
    add(1,1,0,15, 2,  0, 5,0);
    add(1,0,0,15, 1,  0, 5,0);
    add(1,0,0,15, 6,  0, 5,0);
    add(1,1,0,15, 1,  0, 5,0);
    add(1,1,0,15, 1,  1, 6,0);
    add(1,1,0,15, 3,  1, 6,0);
    add(1,1,0,15, 1,  2, 7,0);
    // peak lowered 15->6 at ch0=9 rising
    add(0,1,0,15, 1,  0, 5,0);
    add(1,1,0,15,36,  9,14,0);
    add(1,1,0, 6, 3,  9,14,0);
    add(1,1,0, 6, 1,  6, 6,0);
    add(1,1,0, 6, 4,  5, 5,0);
    add(1,1,0, 6, 4,  4, 4,0);
    // SAW_UP, SAW_DOWN, HOLD
    add(0,1,0,15, 1,  0, 5,0);
    add(1,1,0,15,52, 13,12,0);
    add(1,1,1,15, 4, 14,13,0);
    add(1,1,1,15, 4, 15,14,0);
    add(1,1,1,15, 4,  0,15,1);
    add(1,1,1,15, 1,  0,15,0);
    add(1,1,1,15, 3,  1, 0,0);
    add(1,1,2,15, 4,  0,15,0);
    add(1,1,2,15, 4, 15,14,1);
    add(1,1,2,15, 4, 14,13,0);
    add(1,1,3,15, 4, 14,13,0);
    add(1,1,3,15, 4, 14,13,0);
    add(1,1,3,15, 4, 14,13,0);
    // back to TRIANGLE, then one-cycle reset at ch0=11
    add(1,1,0,15, 4, 15,12,0);
    add(1,1,0,15,16, 11, 8,0);
    add(1,1,0,15, 1, 11, 8,0);
    add(0,1,0,15, 1,  0, 5,0);
    add(1,1,0,15, 3,  0, 5,0);
    add(1,1,0,15, 1,  1, 6,0);
    // peak == 0: pulse every tick, none in HOLD
    add(0,1,0, 0, 1,  0, 0,0);
    add(1,1,0, 0, 4,  0, 0,1);
    add(1,1,0, 0, 1,  0, 0,0);
    add(1,1,0, 0, 3,  0, 0,1);
    add(1,1,3, 0, 4,  0, 0,0);

    reset = 1'b0; enable = 1'b1; mode = 2'd0; pk1 = 4'd15; pk4 = 4'd10;
    adv(2);
    chk("rst_d1_ch0", br1[3:0], 4'd0);
    chk("rst_d1_ch1", br1[7:4], 4'd5);
    chk("rst_d1_cs",  {3'b000, cs1}, 4'd0);
    chk("rst_d4_ch0", br4[3:0], 4'd0);
    chk("rst_d4_ch1", br4[7:4], 4'd5);
    chk("rst_d4_cs",  {3'b000, cs4}, 4'd0);
    reset = 1'b1;

    // free-running triangle, both step sizes, across one full period
    for (int t = 0; t <= 125; t++) begin
      if (t > 0) adv(1);
      s = t / 4;
      chk($sformatf("tri_d1_ch0_t%0d", t), br1[3:0], 4'(tri30(s % 30)));
      chk($sformatf("tri_d1_ch1_t%0d", t), br1[7:4], 4'(tri30((s + 5) % 30)));
      chk($sformatf("tri_d1_cs_t%0d", t), {3'b000, cs1}, {3'b000, (t > 0 && t % 120 == 0)});
      chk($sformatf("tri_d4_ch0_t%0d", t), br4[3:0], 4'(seq4[s % 6]));
      chk($sformatf("tri_d4_cs_t%0d", t), {3'b000, cs4}, {3'b000, (t > 0 && t % 24 == 0)});
    end

    foreach (tbl[i]) begin
      reset  = tbl[i].rst;
      enable = tbl[i].en;
      mode   = tbl[i].md;
      pk1    = tbl[i].pk;
      adv(tbl[i].adv);
      chk($sformatf("vec%0d_ch0", i), br1[3:0], tbl[i].e0);
      chk($sformatf("vec%0d_ch1", i), br1[7:4], tbl[i].e1);
      chk($sformatf("vec%0d_cs", i), {3'b000, cs1}, {3'b000, tbl[i].ecs});
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/brightness_sequencer.md
Name: brightness_sequencer

Overview:
- Multi-channel, parametrised successor to the single-channel triangle brightness stepper.
- Produces CHANNELS staggered brightness levels of WIDTH bits each, stepping once every IDLE_TIME clocks.
- Adds a runtime peak, step size, pause control and four waveform modes.
- Feeds the PWM generator bank: one duty input per channel; cycle_start is a sync marker for the downstream logic.

Parameters:
- WIDTH, 8, bits per brightness value.
- CHANNELS, 3, number of independent output channels.
- IDLE_TIME, 16, clocks each value is held (>=1).
- STEP, 1, increment/decrement per step tick (1..2^WIDTH-1).
- STAGGER, 4, reset-value offset between adjacent channels; (CHANNELS-1)*STAGGER <= 2^WIDTH-1.

Ports:
- clk  in  1  clock; all logic on posedge.
- reset  in  1  synchronous, active-low reset.
- enable  in  1  1 = run; 0 = freeze prescaler, values and directions.
- mode  in  2  0 TRIANGLE, 1 SAW_UP, 2 SAW_DOWN, 3 HOLD.
- peak  in  WIDTH  upper bound of every channel (lower bound fixed at 0).
- brightness  out  CHANNELS*WIDTH  channel k occupies bits [k*WIDTH +: WIDTH].
- cycle_start  out  1  one-cycle pulse marking channel 0 period start.

Behaviour:
- Reset (reset==0 at posedge):
  - prescaler = 0.
  - channel k value = min(k*STAGGER, peak).
  - channel k dir = up, or down if value == peak and peak != 0.
  - cycle_start = 0.
  - Reset overrides enable and mode. It applies mid-operation with no residue: the next value is held a full IDLE_TIME after release.
- Prescaler:
  - Counts 0..IDLE_TIME-1 while enable==1.
  - tick = enable && prescaler==IDLE_TIME-1; on tick, prescaler returns to 0.
  - enable==0 holds the count (pause resumes with the remaining count).
- Output timing: all channel updates occur on the tick edge. Outputs are registered, so each value is visible exactly IDLE_TIME enabled cycles. No combinational path from inputs to outputs.
- Arithmetic: done in WIDTH+1 bits, no wrap.
  - up: if v+STEP >= peak then v = peak, else v += STEP.
  - down: if v <= STEP then v = 0, else v -= STEP.
- TRIANGLE:
  - dir up: step up; on reaching peak, dir = down.
  - dir down: step down; on reaching 0, dir = up.
  - Bounds are held exactly one step period.
- SAW_UP: step up; a tick while v == peak loads 0.
- SAW_DOWN: step down; a tick while v == 0 loads peak.
- HOLD: values and dir unchanged on tick; prescaler keeps running.
- Mode change: sampled at each tick. The current value is kept and the new rule applies from that tick. The stored dir is kept for TRIANGLE.
- Runtime peak:
  - Sampled at each tick.
  - If v > peak at a tick (any mode except HOLD): v = peak, and dir = down if TRIANGLE.
  - peak == 0: all values become 0 on the next tick (non-HOLD).
- cycle_start:
  - Registered; high for the one cycle after the tick edge where channel 0 output newly becomes 0 (TRIANGLE, SAW_UP) or newly becomes peak (SAW_DOWN).
  - With peak==0 it pulses every tick; it never pulses in HOLD.

Test Plan:
1. WIDTH=4, CHANNELS=2, IDLE_TIME=4, STEP=1, STAGGER=5, peak=15, TRIANGLE, enable=1, reset released:
   - ch0 holds 0 for 4 cycles, then 1..15, then 14..0; period 120 cycles.
   - ch1 starts at 5 and ramps up.
   - cycle_start pulses every 120 cycles when ch0 enters 0.
2. Same config, enable low for 7 cycles when prescaler==2:
   - outputs frozen; after re-enable the current value holds 1 more cycle, then steps.
3. STEP=4, peak=10, TRIANGLE:
   - ch0 sequence 0,4,8,10,6,2,0,4, each value held IDLE_TIME cycles.
4. peak lowered 15->6 while ch0=9 ascending:
   - next tick ch0=6 with dir down; following ticks give 5,4.
5. Mode sequences with peak=15:
   - SAW_UP: 14,15,0,1, with cycle_start on entry to 0.
   - SAW_DOWN: 1,0,15,14, with cycle_start on entry to 15.
   - HOLD for 3 ticks: value constant, no cycle_start.
6. Reset low for one cycle mid-ramp (ch0=11):
   - next cycle ch0=0, ch1=5, cycle_start=0, prescaler=0.
   - first step occurs exactly 4 cycles after release.
